store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Downstream consumer of the store-data filter. Takes the zero-extended store data plus address
//   and size flags, aligns data to its byte lane, and generates byte enables.
//   Queues stores in a small FIFO and drains them to the data-memory write port over a req/ack handshake.
//   Flags loads that hit a pending store word so the pipeline can stall them.
// PARAMETERS
//   DEPTH       4    FIFO entries; power of 2, >= 2
//   ADDR_W      32   byte-address width
// PORTS
//   clk           in   1       rising-edge clock
//   rst_n         in   1       asynchronous active-low reset
//   st_valid      in   1       store issued this cycle
//   st_addr       in   ADDR_W  store byte address
//   st_data       in   32      filtered store data (byte/half already zero-extended in low bits)
//   st_sb         in   1       byte store
//   st_sh         in   1       halfword store (wins if st_sb also set)
//   st_stall      out  1       buffer full; store not accepted, pipeline holds
//   st_misalign   out  1       pulse: accepted-cycle store was misaligned and dropped
//   ld_valid      in   1       load issued this cycle
//   ld_addr       in   ADDR_W  load byte address
//   ld_hazard     out  1       load word matches a pending store word
//   mem_req       out  1       write request to data memory
//   mem_addr      out  ADDR_W  word-aligned address ([1:0]=0)
//   mem_wdata     out  32      lane-aligned write data
//   mem_be        out  4       byte enables, bit i = byte lane i
//   mem_ack       in   1       memory accepts the current request
//   empty         out  1       no pending stores
// BEHAVIOUR
//   - Reset: pointers and count 0; empty=1; st_stall, st_misalign, ld_hazard, mem_req 0;
//     mem_addr, mem_wdata, mem_be 0.
//   - Lane alignment, with o = st_addr[1:0]:
//       byte: wdata = st_data[7:0] << 8*o;       be = 4'b0001 << o
//       half: wdata = st_data[15:0] << 16*o[1];  be = 4'b0011 << 2*o[1]
//       word: wdata = st_data;                   be = 4'b1111
//   - Misaligned stores (half with o[0]=1; word with o!=0): not enqueued; st_misalign=1 for that cycle only.
//   - Push: st_valid & ~st_stall & aligned. Entry holds {st_addr[ADDR_W-1:2], wdata, be}.
//   - st_stall is combinational: count==DEPTH. A push is refused while full, even if a pop happens in the same cycle.
//   - Drain handshake:
//       mem_req=1 whenever count!=0; mem_* present the head entry, combinational from FIFO storage.
//       Outputs hold stable until the cycle mem_req & mem_ack; the head pops at that clock edge.
//       mem_ack while mem_req=0 is ignored.
//   - Simultaneous push and pop: count unchanged; the new entry is written at the tail.
//     With count==0, push and pop cannot coincide (mem_req=0). Latency push -> mem_req is 1 cycle.
//   - Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
//   - ld_hazard (combinational) = ld_valid & any valid entry with word addr == ld_addr[ADDR_W-1:2].
//     The store presented on st_* in the same cycle is NOT compared; the pipeline orders it one stage earlier.
//   - Reset mid-operation: all pending stores are discarded; mem_req drops asynchronously.
// STRUCTURE
//   - Shared header store_defs.vh:
//       BE_BYTE0=4'b0001, BE_HALF0=4'b0011, BE_WORD=4'b1111
//       size encoding SZ_BYTE/SZ_HALF/SZ_WORD
//       STORE_BUF_DEPTH default
//   - Sub-module store_lane_align (combinational): {addr[1:0], data, sb, sh} -> {wdata, be, misalign}.
//   - store_buffer instantiates it, plus the FIFO regs, pointer/count logic and hazard comparators.
// TESTING
//   1. Reset then idle: empty=1, mem_req=0, st_stall=0 throughout.
//   2. sb addr=0x103 data=0x000000AB, ack next cycle
//        -> mem_addr=0x100, be=4'b1000, wdata=0xAB000000, one write.
//   3. Four word stores with mem_ack=0 -> st_stall=1 after the fourth; fifth held.
//      Release ack one cycle -> one pop, st_stall=0, then fifth accepted.
//   4. sh addr=0x201 -> st_misalign=1 one cycle, count unchanged.
//      sh addr=0x202 data=0xBEEF -> be=4'b1100, wdata=0xBEEF0000.
//   5. Pending store to 0x300; load 0x302 -> ld_hazard=1; load 0x304 -> 0.
//      After ack drains the store, load 0x302 -> 0.
//   6. Push and ack in the same cycle with count=2 -> count stays 2, order preserved.
//      Assert rst_n low mid-stream -> mem_req=0 immediately, empty=1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: byte-enable patterns,
// store size encoding and the default queue depth.
package store_buffer_pkg;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    localparam int STORE_BUF_DEPTH = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } sz_e;

endpackage

// File: rtl/store_lane_align.sv
// Moves zero-extended store data onto its byte lane, builds the
// byte enables and flags misaligned halfword/word stores.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    input  logic        i_sb,
    input  logic        i_sh,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign
);

    sz_e w_sz;

    // halfword wins when both size flags are set
    assign w_sz = i_sh ? SZ_HALF : (i_sb ? SZ_BYTE : SZ_WORD);

    always_comb begin
        o_wdata    = i_data;
        o_be       = BE_WORD;
        o_misalign = 1'b0;
        unique case (w_sz)
            SZ_BYTE: begin
                o_wdata = {24'b0, i_data[7:0]} << {i_off, 3'b000};
                o_be    = BE_BYTE0 << i_off;
            end
            SZ_HALF: begin
                o_wdata    = {16'b0, i_data[15:0]} << {i_off[1], 4'b0000};
                o_be       = BE_HALF0 << {i_off[1], 1'b0};
                o_misalign = i_off[0];
            end
            default: begin
                o_misalign = (i_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store queue: aligns stores, buffers them in a small FIFO, drains
// them over a req/ack write port and flags loads to pending words.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = STORE_BUF_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_sb,
    input  logic              st_sh,
    output logic              st_stall,
    output logic              st_misalign,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-3:0] r_addr [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [3:0]        r_be   [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_mis;
    logic        w_push;
    logic        w_pop;
    logic        w_hit;
    logic [1:0]  w_unused;

    store_lane_align u_align (
        .i_off      (st_addr[1:0]),
        .i_data     (st_data),
        .i_sb       (st_sb),
        .i_sh       (st_sh),
        .o_wdata    (w_wdata),
        .o_be       (w_be),
        .o_misalign (w_mis)
    );

    assign st_stall    = (r_count == CW'(DEPTH));
    assign st_misalign = st_valid & ~st_stall & w_mis;
    assign w_push      = st_valid & ~st_stall & ~w_mis;
    assign mem_req     = (r_count != '0);
    assign w_pop       = mem_req & mem_ack;
    assign empty       = ~mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_be[i]   <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_addr[r_wptr] <= st_addr[ADDR_W-1:2];
                r_data[r_wptr] <= w_wdata;
                r_be[r_wptr]   <= w_be;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // head outputs are forced to zero while nothing is pending
    assign mem_addr  = mem_req ? {r_addr[r_rptr], 2'b00} : '0;
    assign mem_wdata = mem_req ? r_data[r_rptr] : '0;
    assign mem_be    = mem_req ? r_be[r_rptr] : '0;

    // an entry is live when its distance from the head is below count
    always_comb begin
        logic [PW-1:0] v_dist;
        w_hit  = 1'b0;
        v_dist = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_dist = PW'(i) - r_rptr;
            if (({1'b0, v_dist} < r_count) &&
                (r_addr[i] == ld_addr[ADDR_W-1:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid & w_hit;
    assign w_unused  = ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed-vector bench for store_buffer with hand-computed
// expected values.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_sb;
    logic        st_sh;
    logic        st_stall;
    logic        st_misalign;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;

    int n_vec;
    int n_err;
    int n_wr;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_sb       (st_sb),
        .st_sh       (st_sh),
        .st_stall    (st_stall),
        .st_misalign (st_misalign),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && mem_ack) n_wr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic sb, input logic sh);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_sb    = sb;
        st_sh    = sh;
        step();
        st_valid = 1'b0;
        st_sb    = 1'b0;
        st_sh    = 1'b0;
        #1;
    endtask

    task automatic ack_one();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
    endtask

    int wr0;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        n_wr     = 0;
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_sb    = 1'b0;
        st_sh    = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        mem_ack  = 1'b0;

        // 1: reset and idle
        #12;
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_stall", {31'b0, st_stall}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", {28'b0, mem_be}, 32'd0);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_req", {31'b0, mem_req}, 32'd0);
            check("idle_empty", {31'b0, empty}, 32'd1);
            check("idle_stall", {31'b0, st_stall}, 32'd0);
        end
        mem_ack = 1'b0;
        check("idle_nowr", n_wr, 32'd0);

        // 2: byte store to lane 3
        wr0 = n_wr;
        store(32'h103, 32'h0000_00AB, 1'b1, 1'b0);
        check("sb_req", {31'b0, mem_req}, 32'd1);
        check("sb_addr", mem_addr, 32'h100);
        check("sb_be", {28'b0, mem_be}, 32'h8);
        check("sb_wdata", mem_wdata, 32'hAB00_0000);
        ack_one();
        check("sb_writes", n_wr - wr0, 32'd1);
        check("sb_empty", {31'b0, empty}, 32'd1);
        store(32'h101, 32'h0000_0012, 1'b1, 1'b0);
        check("sb1_be", {28'b0, mem_be}, 32'h2);
        check("sb1_wdata", mem_wdata, 32'h0000_1200);
        ack_one();

        // 3: fill, stall, release one
        for (int i = 0; i < 4; i++) begin
            check("fill_nostall", {31'b0, st_stall}, 32'd0);
            store(32'h400 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0, 1'b0);
        end
        check("full_stall", {31'b0, st_stall}, 32'd1);
        check("full_head", mem_addr, 32'h400);
        check("full_be", {28'b0, mem_be}, 32'hF);
        st_valid = 1'b1;
        st_addr  = 32'h410;
        st_data  = 32'h1111_0004;
        step();
        check("held_stall", {31'b0, st_stall}, 32'd1);
        check("held_head", mem_addr, 32'h400);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check("rel_stall", {31'b0, st_stall}, 32'd0);
        check("rel_head", mem_addr, 32'h404);
        step();
        st_valid = 1'b0;
        #1;
        check("fifth_in", {31'b0, st_stall}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            check("drain_addr", mem_addr, 32'h400 + 32'(4 * i));
            check("drain_data", mem_wdata, 32'h1111_0000 + 32'(i));
            ack_one();
        end
        check("drain_empty", {31'b0, empty}, 32'd1);

        // 4: misaligned half, then aligned upper half
        st_valid = 1'b1;
        st_addr  = 32'h201;
        st_data  = 32'h0000_BEEF;
        st_sh    = 1'b1;
        #1;
        check("mis_pulse", {31'b0, st_misalign}, 32'd1);
        step();
        st_valid = 1'b0;
        st_sh    = 1'b0;
        #1;
        check("mis_drop", {31'b0, st_misalign}, 32'd0);
        check("mis_empty", {31'b0, empty}, 32'd1);
        store(32'h202, 32'h0000_BEEF, 1'b0, 1'b1);
        check("sh_addr", mem_addr, 32'h200);
        check("sh_be", {28'b0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEF_0000);
        ack_one();

        // 5: load hazard
        store(32'h300, 32'h0000_0001, 1'b0, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 32'h302;
        #1;
        check("hz_hit", {31'b0, ld_hazard}, 32'd1);
        ld_addr = 32'h304;
        #1;
        check("hz_miss", {31'b0, ld_hazard}, 32'd0);
        ld_valid = 1'b0;
        ld_addr  = 32'h302;
        #1;
        check("hz_noval", {31'b0, ld_hazard}, 32'd0);
        ack_one();
        ld_valid = 1'b1;
        #1;
        check("hz_drained", {31'b0, ld_hazard}, 32'd0);
        st_valid = 1'b1;
        st_addr  = 32'h500;
        ld_addr  = 32'h500;
        #1;
        check("hz_sameclk", {31'b0, ld_hazard}, 32'd0);
        st_valid = 1'b0;
        ld_valid = 1'b0;
        #1;

        // 6: push with pop, then reset mid-stream
        store(32'h600, 32'hA0, 1'b0, 1'b0);
        store(32'h604, 32'hA1, 1'b0, 1'b0);
        st_valid = 1'b1;
        st_addr  = 32'h608;
        st_data  = 32'hA2;
        mem_ack  = 1'b1;
        step();
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check("pp_head", mem_addr, 32'h604);
        ack_one();
        check("pp_next", mem_addr, 32'h608);
        check("pp_data", mem_wdata, 32'hA2);
        ack_one();
        check("pp_empty", {31'b0, empty}, 32'd1);
        store(32'h700, 32'hB0, 1'b0, 1'b0);
        store(32'h704, 32'hB1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'b0, mem_req}, 32'd0);
        check("arst_empty", {31'b0, empty}, 32'd1);
        check("arst_addr", mem_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_empty", {31'b0, empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
